// File: rtl/router_pkg.sv
// Shared router types and constants for the output-port arbiters.
package router_pkg;

    // Arbitration policy: fixed priority (lowest index wins) or round-robin.
    typedef enum logic {
        ARB_FIXED = 1'b0,
        ARB_RR    = 1'b1
    } arb_mode_e;

    // Arbiter control state: no owner, or a packet currently owns the output.
    typedef enum logic {
        ARB_IDLE = 1'b0,
        ARB_HOLD = 1'b1
    } arb_state_e;

    // Radix of the router; default width of every output-port arbiter.
    localparam int ROUTER_PORTS = 16;

endpackage : router_pkg

// File: rtl/rr_pick.sv
// Rotating priority pick: returns the first set bit of vec at or above base,
// wrapping modulo N. Purely combinational.
module rr_pick
    import router_pkg::*;
#(
    parameter  int N  = ROUTER_PORTS,
    localparam int IW = $clog2(N)
) (
    input  logic [N-1:0]  vec,
    input  logic [IW-1:0] base,
    output logic [N-1:0]  onehot,
    output logic [IW-1:0] idx
);

    logic [N-1:0]   upper_mask;
    logic [2*N-1:0] dbl_vec;
    logic           found;

    // Double-width masked priority encoder: the low copy only holds bits at or
    // above base, the high copy supplies the wrapped-around bits below base.
    always_comb begin
        // NOTE: every output of a combinational block gets a default first so
        // no path leaves it unassigned, which would infer a latch.
        upper_mask = '0;
        found      = 1'b0;
        idx        = '0;
        onehot     = '0;
        // NOTE: blocking assignments here so the found flag updated in one loop
        // iteration is seen by the next one in the same evaluation.
        for (int i = 0; i < N; i++) begin
            upper_mask[i] = (IW'(i) >= base);
        end
        dbl_vec = {vec, vec & upper_mask};
        for (int j = 0; j < 2 * N; j++) begin
            if (!found && dbl_vec[j]) begin
                found = 1'b1;
                idx   = IW'(j % N);
            end
        end
        if (found) begin
            onehot[idx] = 1'b1;
        end
    end

endmodule : rr_pick

// File: rtl/rr_lock_arbiter.sv
// Per-output-port packet arbiter: picks one requester (round-robin or fixed
// priority), locks the grant until release, request drop or hold timeout, and
// re-arbitrates on the same edge so back-to-back packets see no idle cycle.
module rr_lock_arbiter
    import router_pkg::*;
#(
    parameter  int        N        = ROUTER_PORTS,
    parameter  arb_mode_e MODE     = ARB_RR,
    parameter  int        MAX_HOLD = 0,
    localparam int        IW       = $clog2(N)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [N-1:0]  req,
    input  logic          release_i,
    output logic [N-1:0]  grant,
    output logic [IW-1:0] grant_idx,
    output logic          busy,
    output logic          timeout_o
);

    // Hold counter sized to reach MAX_HOLD-1; one bit when the timeout is off.
    localparam int            HW         = (MAX_HOLD > 0) ? $clog2(MAX_HOLD + 1) : 1;
    localparam bit            TIMEOUT_EN = (MAX_HOLD > 0);
    localparam logic [HW-1:0] HOLD_LAST  = HW'((MAX_HOLD > 0) ? (MAX_HOLD - 1) : 0);
    localparam logic [HW-1:0] HOLD_SAT   = '1;
    localparam logic [IW-1:0] LAST_PORT  = IW'(N - 1);

    arb_state_e    state_q, state_d;
    logic [N-1:0]  grant_q, grant_d;
    logic [IW-1:0] grant_idx_q, grant_idx_d;
    logic [IW-1:0] ptr_q, ptr_d;
    logic [HW-1:0] hold_cnt_q, hold_cnt_d;
    logic          timeout_q, timeout_d;

    logic          rel_explicit;
    logic          rel_drop;
    logic          rel_timeout;
    logic          rearb;
    logic [N-1:0]  cand;
    logic [IW-1:0] pick_base;
    logic [N-1:0]  pick_onehot;
    logic [IW-1:0] pick_idx;

    // Decode release events for the current owner and form the candidate set.
    always_comb begin
        rel_explicit = 1'b0;
        rel_drop     = 1'b0;
        rel_timeout  = 1'b0;
        rearb        = 1'b0;
        cand         = req;
        pick_base    = (MODE == ARB_RR) ? ptr_q : '0;
        if (state_q == ARB_IDLE) begin
            rearb = 1'b1;
        end else begin
            rel_explicit = release_i;
            rel_drop     = ~req[grant_idx_q];
            rel_timeout  = TIMEOUT_EN && (hold_cnt_q == HOLD_LAST)
                           && !rel_explicit && !rel_drop;
            rearb        = rel_explicit || rel_drop || rel_timeout;
            // A timed-out owner is barred from winning the very next slot.
            if (rel_timeout) begin
                cand = req & ~grant_q;
            end
        end
    end

    // One shared picker serves both first arbitration and back-to-back hand-off.
    rr_pick #(
        .N (N)
    ) u_pick (
        .vec    (cand),
        .base   (pick_base),
        .onehot (pick_onehot),
        .idx    (pick_idx)
    );

    // Next-state: grant hand-off, pointer advance and hold counting.
    always_comb begin
        state_d     = state_q;
        grant_d     = grant_q;
        grant_idx_d = grant_idx_q;
        ptr_d       = ptr_q;
        hold_cnt_d  = hold_cnt_q;
        timeout_d   = 1'b0;
        if (rearb) begin
            timeout_d = rel_timeout;
            if (|cand) begin
                state_d     = ARB_HOLD;
                grant_d     = pick_onehot;
                grant_idx_d = pick_idx;
                hold_cnt_d  = '0;
                if (MODE == ARB_RR) begin
                    ptr_d = (pick_idx == LAST_PORT) ? '0 : pick_idx + IW'(1);
                end
            end else begin
                state_d     = ARB_IDLE;
                grant_d     = '0;
                grant_idx_d = '0;
            end
        end else if (hold_cnt_q != HOLD_SAT) begin
            hold_cnt_d = hold_cnt_q + HW'(1);
        end
    end

    // State registers; reset drops the grant immediately, without a clock edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= ARB_IDLE;
            grant_q     <= '0;
            grant_idx_q <= '0;
            ptr_q       <= '0;
            hold_cnt_q  <= '0;
            timeout_q   <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register samples the
            // pre-edge values regardless of statement order.
            state_q     <= state_d;
            grant_q     <= grant_d;
            grant_idx_q <= grant_idx_d;
            ptr_q       <= ptr_d;
            hold_cnt_q  <= hold_cnt_d;
            timeout_q   <= timeout_d;
        end
    end

    assign grant     = grant_q;
    assign grant_idx = grant_idx_q;
    assign busy      = |grant_q;
    assign timeout_o = timeout_q;

endmodule : rr_lock_arbiter

// File: tb/tb_rr_lock_arbiter.sv
// Directed bench for rr_lock_arbiter: three 4-port instances (round-robin,
// fixed priority, round-robin with an 8-cycle hold limit) driven side by side.
module tb_rr_lock_arbiter;
    import router_pkg::*;

    logic       clk;
    logic       reset;

    logic [3:0] req_rr, req_fx, req_to;
    logic       rel_rr, rel_fx, rel_to;
    logic [3:0] grant_rr, grant_fx, grant_to;
    logic [1:0] idx_rr, idx_fx, idx_to;
    logic       busy_rr, busy_fx, busy_to;
    logic       to_rr, to_fx, to_to;

    int vectors     = 0;
    int miscompares = 0;

    rr_lock_arbiter #(.N(4), .MODE(ARB_RR), .MAX_HOLD(0)) u_rr (
        .clk(clk), .reset(reset), .req(req_rr), .release_i(rel_rr),
        .grant(grant_rr), .grant_idx(idx_rr), .busy(busy_rr), .timeout_o(to_rr)
    );

    rr_lock_arbiter #(.N(4), .MODE(ARB_FIXED), .MAX_HOLD(0)) u_fx (
        .clk(clk), .reset(reset), .req(req_fx), .release_i(rel_fx),
        .grant(grant_fx), .grant_idx(idx_fx), .busy(busy_fx), .timeout_o(to_fx)
    );

    rr_lock_arbiter #(.N(4), .MODE(ARB_RR), .MAX_HOLD(8)) u_to (
        .clk(clk), .reset(reset), .req(req_to), .release_i(rel_to),
        .grant(grant_to), .grant_idx(idx_to), .busy(busy_to), .timeout_o(to_to)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance one clock and settle just after the rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [3:0] exp_g;

        reset  = 1'b1;
        req_rr = '0; req_fx = '0; req_to = '0;
        rel_rr = 1'b0; rel_fx = 1'b0; rel_to = 1'b0;
        repeat (2) @(posedge clk);
        #1;

        // Reset state of every instance.
        check("rst_grant_rr", grant_rr, 4'b0000);
        check("rst_idx_rr",   idx_rr,   2'd0);
        check("rst_busy_rr",  busy_rr,  1'b0);
        check("rst_to_rr",    to_rr,    1'b0);
        check("rst_grant_fx", grant_fx, 4'b0000);
        check("rst_grant_to", grant_to, 4'b0000);
        check("rst_to_to",    to_to,    1'b0);
        reset = 1'b0;

        // Round-robin rotation, release every third cycle, no idle bubble.
        req_rr = 4'b1111;
        step();
        for (int k = 0; k < 7; k++) begin
            exp_g = 4'b0001 << (k % 4);
            for (int c = 0; c < 3; c++) begin
                check($sformatf("rr_grant_k%0d_c%0d", k, c), grant_rr, exp_g);
                check($sformatf("rr_idx_k%0d_c%0d", k, c), idx_rr, k % 4);
                check($sformatf("rr_busy_k%0d_c%0d", k, c), busy_rr, 1'b1);
                if (c == 2) rel_rr = 1'b1;
                step();
                rel_rr = 1'b0;
            end
        end
        check("rr_grant_hold_1000", grant_rr, 4'b1000);

        // Fixed priority: lowest index wins, owner re-granted when lowest.
        req_fx = 4'b1010;
        step();
        check("fx_first_grant", grant_fx, 4'b0010);
        check("fx_first_idx",   idx_fx,   2'd1);
        check("fx_first_busy",  busy_fx,  1'b1);
        rel_fx = 1'b1;
        req_fx = 4'b1110;
        step();
        rel_fx = 1'b0;
        check("fx_regrant", grant_fx, 4'b0010);
        check("fx_regrant_idx", idx_fx, 2'd1);
        step();
        check("fx_no_preempt", grant_fx, 4'b0010);
        rel_fx = 1'b1;
        req_fx = 4'b1100;
        step();
        rel_fx = 1'b0;
        check("fx_next_lowest", grant_fx, 4'b0100);
        check("fx_next_idx", idx_fx, 2'd2);

        // Owner drop hands off back-to-back, then a full drop goes idle.
        req_fx = 4'b0010;
        step();
        check("fx_drop_handoff", grant_fx, 4'b0010);
        check("fx_drop_handoff_busy", busy_fx, 1'b1);
        req_fx = 4'b0000;
        step();
        check("fx_drop_grant", grant_fx, 4'b0000);
        check("fx_drop_busy", busy_fx, 1'b0);
        rel_fx = 1'b1;
        step();
        rel_fx = 1'b0;
        check("fx_idle_release_grant", grant_fx, 4'b0000);
        check("fx_idle_release_busy", busy_fx, 1'b0);
        check("fx_idle_release_to", to_fx, 1'b0);

        // Hold limit: port 2 held 8 cycles, then timeout hands to port 0.
        req_to = 4'b0100;
        step();
        check("to_first_grant", grant_to, 4'b0100);
        req_to = 4'b0101;
        for (int c = 0; c < 8; c++) begin
            check($sformatf("to_hold_grant_c%0d", c), grant_to, 4'b0100);
            check($sformatf("to_hold_pulse_c%0d", c), to_to, 1'b0);
            step();
        end
        check("to_after_grant", grant_to, 4'b0001);
        check("to_after_idx", idx_to, 2'd0);
        check("to_pulse", to_to, 1'b1);
        check("to_pulse_busy", busy_to, 1'b1);

        // Release on the limit cycle: no pulse, normal RR order (ptr = 1).
        req_to = 4'b1111;
        for (int c = 1; c < 8; c++) begin
            step();
            check($sformatf("to_lim_grant_c%0d", c), grant_to, 4'b0001);
            check($sformatf("to_lim_pulse_c%0d", c), to_to, 1'b0);
            if (c == 7) rel_to = 1'b1;
        end
        step();
        rel_to = 1'b0;
        check("to_lim_next_grant", grant_to, 4'b0010);
        check("to_lim_next_idx", idx_to, 2'd1);
        check("to_lim_no_pulse", to_to, 1'b0);
        step();
        check("to_lim_still_no_pulse", to_to, 1'b0);
        check("to_lim_hold", grant_to, 4'b0010);

        // Reset mid-packet clears the grant with no clock edge.
        check("rr_pre_reset_grant", grant_rr, 4'b1000);
        #2;
        reset = 1'b1;
        #1;
        check("mid_rst_grant", grant_rr, 4'b0000);
        check("mid_rst_busy", busy_rr, 1'b0);
        check("mid_rst_idx", idx_rr, 2'd0);
        check("mid_rst_grant_to", grant_to, 4'b0000);
        #3;
        reset = 1'b0;
        step();
        check("post_rst_grant", grant_rr, 4'b0001);
        check("post_rst_idx", idx_rr, 2'd0);
        check("post_rst_busy", busy_rr, 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule : tb_rr_lock_arbiter
